crc_frame_ctrl: RTL and testbench

Frame sequencer for the serial LSB-first CRC engine (8-bit, seed 0xD8, taps 0x44). It accepts bytes over a valid/ready handshake and reseeds the engine at frame start. Each byte is serialized LSB-first into the engine with `active` held continuously across the frame. It then collects the engine's serial CRC output into a parallel word and pulses `done`. The same bit stream, data then CRC, is mirrored on a tx port for the downstream serializer.

---
 rtl/crc_frame_ctrl.sv | 147 ++++++++++++++
 tb/tb_crc_frame_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for a serial LSB-first CRC engine: buffers bytes, serializes them
// into the engine, collects the serial CRC and mirrors the whole bit stream on tx.
module crc_frame_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int DRAIN_TIMEOUT = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  crc_rst_n,
  output logic                  crc_data,
  output logic                  crc_active,
  input  logic                  crc_bit,
  input  logic                  crc_valid,
  output logic                  tx_bit,
  output logic                  tx_valid,
  output logic                  tx_crc,
  output logic [DATA_WIDTH-1:0] crc_out,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  localparam int KW = $clog2(DATA_WIDTH);
  localparam int TW = $clog2(DRAIN_TIMEOUT);
  localparam int CW = DATA_WIDTH - 1;
  localparam logic [KW-1:0] K_LAST = KW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] T_LAST = TW'(DRAIN_TIMEOUT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SEED  = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]            state, state_nxt;
  logic                  hold_full, hold_last, last_seen, cur_last;
  logic [DATA_WIDTH-1:0] hold_data, shreg;
  logic [CW-1:0]         cap;
  logic [KW-1:0]         k, bit_cnt;
  logic [TW-1:0]         drain_cnt;
  logic                  accept, byte_end, reload, cap_end;

  // in_ready only looks at pre-edge hold state, so an accept never collides with a reload
  assign in_ready = !hold_full && !last_seen &&
                    (state == IDLE || state == SEED || state == SHIFT);
  assign accept   = in_valid && in_ready;
  assign byte_end = (state == SHIFT) && (k == K_LAST);
  assign reload   = byte_end && !cur_last && hold_full;
  assign cap_end  = (state == DRAIN) && crc_valid && (bit_cnt == K_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEED;
      SEED:    state_nxt = SHIFT;
      SHIFT: begin
        if (byte_end) begin
          if (cur_last)       state_nxt = DRAIN;
          else if (!hold_full) state_nxt = ERR;
        end
      end
      DRAIN: begin
        if (cap_end)                   state_nxt = DONE;
        else if (drain_cnt == T_LAST)  state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      crc_rst_n <= 1'b0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      cur_last  <= 1'b0;
      last_seen <= 1'b0;
      k         <= '0;
      bit_cnt   <= '0;
      drain_cnt <= '0;
      crc_out   <= '0;
    end else begin
      state     <= state_nxt;
      crc_rst_n <= (state_nxt != SEED);

      if (accept)
        hold_full <= 1'b1;
      else if (state == SEED || reload || state == ERR)
        hold_full <= 1'b0;
      if (accept)
        hold_last <= in_last;
      if (state == SEED || reload)
        cur_last <= hold_last;

      if (state == DONE || state == ERR)
        last_seen <= 1'b0;
      else if (accept && in_last)
        last_seen <= 1'b1;

      if (state == SHIFT)
        k <= byte_end ? '0 : k + 1'b1;
      else
        k <= '0;

      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
        if (crc_valid)
          bit_cnt <= bit_cnt + 1'b1;
      end else begin
        drain_cnt <= '0;
        bit_cnt   <= '0;
      end

      if (cap_end)
        crc_out <= {crc_bit, cap};
    end
  end

  // Datapath registers carry no reset; control flags decide when they are meaningful
  always_ff @(posedge clk) begin
    if (accept)
      hold_data <= in_data;
    if (state == SEED || reload)
      shreg <= hold_data;
    else if (state == SHIFT)
      shreg <= shreg >> 1;
    if (state == DRAIN && crc_valid)
      cap <= (cap >> 1) | (CW'(crc_bit) << (CW - 1));
  end

  assign crc_active = (state == SHIFT);
  assign crc_data   = (state == SHIFT) && shreg[0];
  assign tx_valid   = (state == SHIFT) || ((state == DRAIN) && crc_valid);
  assign tx_bit     = (state == SHIFT) ? shreg[0] : ((state == DRAIN) && crc_bit);
  assign tx_crc     = (state == DRAIN);
  assign done       = (state == DONE);
  assign err        = (state == ERR);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Bench for crc_frame_ctrl: behavioural CRC engine (seed 0xD8, taps 0x44), scoreboard
// queues for the tx bit stream and for done/err events, directed frame sequence.
module tb_crc_frame_ctrl;
  localparam int W = 8;
  localparam int T = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready, crc_rst_n, crc_data, crc_active, crc_bit, crc_valid;
  logic         tx_bit, tx_valid, tx_crc, done, err, busy;
  logic [W-1:0] crc_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  crc_frame_ctrl #(.DATA_WIDTH(W), .DRAIN_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .crc_rst_n(crc_rst_n), .crc_data(crc_data),
    .crc_active(crc_active), .crc_bit(crc_bit), .crc_valid(crc_valid),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_crc(tx_crc), .crc_out(crc_out),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
    logic fb;
    fb = c[0] ^ d;
    return {fb, c[7:1]} ^ (fb ? 8'h44 : 8'h00);
  endfunction

  // Engine model: shifts while active, then emits W bits starting the cycle after active falls
  logic [7:0] eng_c = 8'hD8;
  logic [7:0] eng_osr = 8'h00;
  int         eng_cnt = 0;
  logic       eng_prev = 1'b0;
  bit         stuck = 1'b0;

  always @(posedge clk or negedge crc_rst_n) begin
    if (!crc_rst_n) begin
      eng_c    <= 8'hD8;
      eng_osr  <= 8'h00;
      eng_cnt  <= 0;
      eng_prev <= 1'b0;
    end else begin
      eng_prev <= crc_active;
      if (crc_active) eng_c <= crc_step(eng_c, crc_data);
      if (eng_prev && !crc_active) begin
        eng_osr <= eng_c;
        eng_cnt <= W;
      end else if (eng_cnt != 0) begin
        eng_osr <= eng_osr >> 1;
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  assign crc_valid = (eng_cnt != 0) && !stuck;
  assign crc_bit   = eng_osr[0];

  logic [1:0] tx_q[$];
  logic [8:0] ev_q[$];
  logic [1:0] tx_e;
  logic [8:0] ev_e;
  logic [7:0] run_crc = 8'hD8;
  logic [7:0] last_good = 8'h00;
  bit         new_frame = 1'b1;
  logic       prev_act = 1'b0;
  int fstart = 0, last_rise = 0, last_run = 0, act_run = 0;
  int done_cyc = 0, err_cyc = 0, rstn_low = 0, fs_save = 0, base = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        if (crc_active) begin
          if (!prev_act) last_rise = cyc;
          act_run++;
        end else begin
          if (act_run != 0) last_run = act_run;
          act_run = 0;
        end
        prev_act = crc_active;
        if (!crc_rst_n) rstn_low++;
        if (tx_valid) begin
          check("tx_pending", 32'(tx_q.size() != 0), 1);
          if (tx_q.size() != 0) begin
            tx_e = tx_q.pop_front();
            check("tx_bit", 32'({tx_crc, tx_bit}), 32'(tx_e));
          end
        end
        if (done || err) begin
          check("ev_pending", 32'(ev_q.size() != 0), 1);
          if (ev_q.size() != 0) begin
            ev_e = ev_q.pop_front();
            check("ev_result", 32'({err, done, crc_out}), 32'({ev_e[8], !ev_e[8], ev_e[7:0]}));
          end
          if (done) done_cyc = cyc;
          if (err)  err_cyc  = cyc;
        end
      end else begin
        prev_act = 1'b0;
        act_run  = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, input bit exp_err);
    int t;
    @(negedge clk);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", 32'(t < 100), 1);
    if (new_frame) begin
      fstart    = cyc;
      run_crc   = 8'hD8;
      new_frame = 1'b0;
    end
    for (int i = 0; i < W; i++) begin
      tx_q.push_back({1'b0, d[i]});
      run_crc = crc_step(run_crc, d[i]);
    end
    if (last) begin
      new_frame = 1'b1;
      if (exp_err) begin
        ev_q.push_back({1'b1, last_good});
      end else begin
        for (int i = 0; i < W; i++) tx_q.push_back({1'b1, run_crc[i]});
        last_good = run_crc;
        ev_q.push_back({1'b0, run_crc});
      end
    end
    @(posedge clk);
  endtask

  task automatic idle_input();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_events(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (ev_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check(tag, 32'(ev_q.size()), 0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check("rst_crc_rst_n", 32'(crc_rst_n), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done_err", 32'({done, err}), 0);
    check("rst_crc_out", 32'(crc_out), 0);
    check("rst_active", 32'(crc_active), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("crc_rst_n_rise", 32'(crc_rst_n), 1);

    // Single zero byte: known CRC 0x14 and the documented latencies
    send_byte(8'h00, 1'b1, 1'b0);
    idle_input();
    wait_events("t1_wait", 100);
    check("t1_crc_out", 32'(crc_out), 32'h14);
    check("t1_act_lat", 32'(last_rise - fstart), 2);
    check("t1_done_lat", 32'(done_cyc - fstart), 32'(W + W + 3));
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 0);

    // Two bytes with in_valid held: 16 gapless active cycles
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    idle_input();
    wait_events("t2_wait", 100);
    check("t2_active_run", 32'(last_run), 16);
    check("t2_done_lat", 32'(done_cyc - fstart), 32'(2 * W + W + 3));

    // Underrun: second byte 12 cycles late becomes a fresh frame
    send_byte(8'h81, 1'b0, 1'b0);
    fs_save = fstart;
    ev_q.push_back({1'b1, last_good});
    new_frame = 1'b1;
    idle_input();
    repeat (10) @(negedge clk);
    check("t3_err_seen", 32'(ev_q.size()), 0);
    check("t3_err_lat", 32'(err_cyc - fs_save), 10);
    check("t3_active_run", 32'(last_run), 8);
    send_byte(8'h00, 1'b1, 1'b0);
    idle_input();
    wait_events("t3_wait", 100);
    check("t3_reseed_crc", 32'(crc_out), 32'h14);

    // Stuck engine: drain timeout
    stuck = 1'b1;
    send_byte(8'h00, 1'b1, 1'b1);
    idle_input();
    wait_events("t4_wait", 100);
    check("t4_err_lat", 32'(err_cyc - fstart), 32'(2 + W + T));
    @(negedge clk);
    check("t4_busy_after", 32'(busy), 0);
    stuck = 1'b0;

    // Back-to-back single-byte frames
    base = rstn_low;
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    idle_input();
    wait_events("t5_wait", 200);
    check("t5_rstn_low", 32'(rstn_low - base), 2);
    check("t5_crc_out", 32'(crc_out), 32'h14);

    // Three pseudo-random bytes against the reference model
    send_byte(8'($urandom), 1'b0, 1'b0);
    send_byte(8'($urandom), 1'b0, 1'b0);
    send_byte(8'($urandom), 1'b1, 1'b0);
    idle_input();
    wait_events("t6_wait", 200);

    // Asynchronous reset in the middle of SHIFT
    send_byte(8'hFF, 1'b1, 1'b0);
    idle_input();
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t7_crc_rst_n", 32'(crc_rst_n), 0);
    check("t7_active", 32'(crc_active), 0);
    check("t7_busy", 32'(busy), 0);
    check("t7_flags", 32'({done, err, tx_valid}), 0);
    check("t7_crc_out", 32'(crc_out), 0);
    tx_q.delete();
    ev_q.delete();
    last_good = 8'h00;
    new_frame = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    idle_input();
    wait_events("t7_wait", 200);
    check("t7_crc_final", 32'(crc_out), 32'(last_good));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
